// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 bit mux: steps sel through the enabled channels,
// holds each for dwell+1 cycles and samples mux_out on the last edge of each dwell.
module mux4_scan_ctrl #(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [DWELL_W-1:0] dwell_i,
   input  logic [3:0]         mask_i,
   input  logic               mux_out_i,
   output logic [1:0]         sel_o,
   output logic [3:0]         data_o,
   output logic               valid_o,
   output logic               busy_o,
   output logic [1:0]         state_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [1:0]         sel_q;
   logic [3:0]         data_q;
   logic               valid_q;
   logic               busy_q;
   logic [3:0]         shadow_q;
   logic [DWELL_W-1:0] count_q;
   logic [3:0]         mask_q;
   logic [DWELL_W-1:0] dwell_q;

   logic       next_found;
   logic [1:0] next_sel;
   logic [1:0] first_sel;
   logic [3:0] shadow_upd;

   // Scanning from the top down leaves the lowest qualifying index in the result.
   always_comb begin
      next_found = 1'b0;
      next_sel   = 2'd0;
      first_sel  = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (k > int'(sel_q) && mask_q[k]) begin
            next_found = 1'b1;
            next_sel   = 2'(k);
         end
         if (mask_i[k]) begin
            first_sel = 2'(k);
         end
      end
      shadow_upd        = shadow_q;
      shadow_upd[sel_q] = mux_out_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= 2'd0;
         data_q   <= 4'd0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         shadow_q <= 4'd0;
         count_q  <= '0;
         mask_q   <= 4'd0;
         dwell_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               sel_q   <= 2'd0;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
               if (start_i) begin
                  mask_q  <= mask_i;
                  dwell_q <= dwell_i;
                  if (mask_i != 4'd0) begin
                     state_q  <= ST_WAIT;
                     sel_q    <= first_sel;
                     count_q  <= dwell_i;
                     shadow_q <= 4'd0;
                     busy_q   <= 1'b1;
                  end else begin
                     state_q <= ST_DONE;
                     data_q  <= 4'd0;
                     valid_q <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (count_q != '0) begin
                  count_q <= count_q - 1'b1;
               end else begin
                  shadow_q <= shadow_upd;
                  if (next_found) begin
                     sel_q   <= next_sel;
                     count_q <= dwell_q;
                  end else begin
                     state_q <= ST_DONE;
                     data_q  <= shadow_upd;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     sel_q   <= 2'd0;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               sel_q   <= 2'd0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               sel_q   <= 2'd0;
            end
         endcase
      end
   end

   assign sel_o   = sel_q;
   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed-vector bench for mux4_scan_ctrl with a behavioural 4:1 mux on sel.
module tb_mux4_scan_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] dwell;
   logic [3:0] mask;
   logic [3:0] mux_in;
   logic       mux_out;
   logic [1:0] sel;
   logic [3:0] data;
   logic       valid;
   logic       busy;
   logic [1:0] state;

   int n_checks;
   int n_pass;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   mux4_scan_ctrl #(.DWELL_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (start),
      .dwell_i   (dwell),
      .mask_i    (mask),
      .mux_out_i (mux_out),
      .sel_o     (sel),
      .data_o    (data),
      .valid_o   (valid),
      .busy_o    (busy),
      .state_o   (state)
   );

   assign mux_out = mux_in[sel];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a start request and return just after E0 with start dropped.
   task automatic scan_start(input logic [3:0] m, input logic [3:0] d);
      start = 1'b1;
      mask  = m;
      dwell = d;
      step();
      start = 1'b0;
   endtask

   task automatic check_done(input string tag, input logic [3:0] exp_data);
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_data"}, 32'(data), 32'(exp_data));
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_sel"}, 32'(sel), 32'd0);
      check({tag, "_state"}, 32'(state), 32'(S_DONE));
      step();
      check({tag, "_valid_fall"}, 32'(valid), 32'd0);
      check({tag, "_idle"}, 32'(state), 32'(S_IDLE));
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dwell    = 4'd0;
      mask     = 4'd0;
      mux_in   = 4'd0;
      #12;
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_state", 32'(state), 32'(S_IDLE));
      rst_n = 1'b1;
      step();
      step();

      // Full fast scan: one cycle per channel
      mux_in = 4'b1010;
      scan_start(4'b1111, 4'd0);
      for (int j = 0; j < 4; j++) begin
         check("fast_sel", 32'(sel), 32'(j));
         check("fast_busy", 32'(busy), 32'd1);
         check("fast_novalid", 32'(valid), 32'd0);
         step();
      end
      check_done("fast", 4'b1010);

      // Sparse mask with dwell 3
      mux_in = 4'b1111;
      scan_start(4'b0101, 4'd3);
      for (int i = 0; i < 8; i++) begin
         check("sparse_sel", 32'(sel), (i < 4) ? 32'd0 : 32'd2);
         check("sparse_busy", 32'(busy), 32'd1);
         step();
      end
      check_done("sparse", 4'b0101);

      // Empty mask overwrites previous nonzero result
      scan_start(4'b0000, 4'd5);
      check("empty_busy", 32'(busy), 32'd0);
      check_done("empty", 4'b0000);

      // Sample point: only the last dwell cycle counts
      mux_in = 4'b0000;
      scan_start(4'b0001, 4'd2);
      step();
      mux_in = 4'b0001;
      step();
      step();
      check_done("samp_hi", 4'b0001);
      mux_in = 4'b0001;
      scan_start(4'b0001, 4'd2);
      step();
      mux_in = 4'b0000;
      step();
      step();
      check_done("samp_lo", 4'b0000);

      // Maximum dwell: 16 cycles on the single channel
      mux_in = 4'b0010;
      scan_start(4'b0010, 4'd15);
      for (int i = 0; i < 16; i++) begin
         check("maxdw_sel", 32'(sel), 32'd1);
         check("maxdw_busy", 32'(busy), 32'd1);
         step();
      end
      check_done("maxdw", 4'b0010);

      // Inputs changed and start held during WAIT/DONE are ignored
      mux_in = 4'b1111;
      scan_start(4'b0011, 4'd1);
      start = 1'b1;
      mask  = 4'b1111;
      dwell = 4'd0;
      for (int i = 0; i < 4; i++) begin
         check("ign_sel", 32'(sel), (i < 2) ? 32'd0 : 32'd1);
         check("ign_state", 32'(state), 32'(S_WAIT));
         step();
      end
      check("ign_valid", 32'(valid), 32'd1);
      check("ign_data", 32'(data), 32'b0011);
      start = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         check("ign_no_restart", 32'(state), 32'(S_IDLE));
         check("ign_no_valid", 32'(valid), 32'd0);
         step();
      end

      // Asynchronous reset mid-WAIT with sel=2
      mux_in = 4'b0100;
      scan_start(4'b0100, 4'd3);
      check("pre_rst_sel", 32'(sel), 32'd2);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_sel", 32'(sel), 32'd0);
      check("arst_data", 32'(data), 32'd0);
      check("arst_valid", 32'(valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_state", 32'(state), 32'(S_IDLE));
      #2;
      rst_n = 1'b1;
      step();
      mux_in = 4'b1000;
      scan_start(4'b1000, 4'd0);
      check("post_rst_sel", 32'(sel), 32'd3);
      check("post_rst_busy", 32'(busy), 32'd1);
      step();
      check_done("post_rst", 4'b1000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
